// File: rtl/decode_stage.sv
// Pipelined instruction decode: field split, two-port register file read with
// write-through bypass, and a valid/ready output register with stall and flush.
module decode_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int IMM_WIDTH      = 7,
    parameter int ZERO_REG       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instruction,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    output logic [DATA_WIDTH-1:0]     sign_extended_immediate
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int RS_MSB   = INSTR_WIDTH - OPCODE_WIDTH - 1;
    localparam int RT_MSB   = RS_MSB - REG_ADDR_WIDTH;
    localparam int RD_MSB   = RT_MSB - REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
    logic [OPCODE_WIDTH-1:0]   opcode_f;
    logic [REG_ADDR_WIDTH-1:0] rs_f, rt_f, rd_f;
    logic [IMM_WIDTH-1:0]      imm_f;
    logic [DATA_WIDTH-1:0]     ext_f;
    logic [DATA_WIDTH-1:0]     op1_in, op2_in;
    logic                      held1_hit, held2_hit;
    logic                      load;

    // Index 0 is hardwired to zero only when ZERO_REG is enabled.
    function automatic logic is_zero(input logic [REG_ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign opcode_f = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign rs_f     = instruction[RS_MSB -: REG_ADDR_WIDTH];
    assign rt_f     = instruction[RT_MSB -: REG_ADDR_WIDTH];
    assign rd_f     = instruction[RD_MSB -: REG_ADDR_WIDTH];
    assign imm_f    = instruction[IMM_WIDTH-1:0];
    assign ext_f    = DATA_WIDTH'($signed(imm_f));

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        op1_in = regs[rs_f];
        if (wb_en && wb_addr == rs_f) op1_in = wb_data;
        if (is_zero(rs_f)) op1_in = '0;

        op2_in = regs[rt_f];
        if (wb_en && wb_addr == rt_f) op2_in = wb_data;
        if (is_zero(rt_f)) op2_in = '0;

        held1_hit = wb_en && (wb_addr == rs) && !is_zero(rs);
        held2_hit = wb_en && (wb_addr == rt) && !is_zero(rt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because reset must
            // leave every register reading 0; this keeps it out of block RAM.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            out_valid               <= 1'b0;
            opcode                  <= '0;
            rs                      <= '0;
            rt                      <= '0;
            rd                      <= '0;
            read_data_1             <= '0;
            read_data_2             <= '0;
            sign_extended_immediate <= '0;
        end else begin
            if (wb_en && !is_zero(wb_addr)) regs[wb_addr] <= wb_data;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid               <= 1'b1;
                opcode                  <= opcode_f;
                rs                      <= rs_f;
                rt                      <= rt_f;
                rd                      <= rd_f;
                read_data_1             <= op1_in;
                read_data_2             <= op2_in;
                sign_extended_immediate <= ext_f;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                // Stalled instruction tracks write-backs to its sources.
                if (held1_hit) read_data_1 <= wb_data;
                if (held2_hit) read_data_2 <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-cycle behaviour
// plus hand-written stall, flush and reset sequences.
module tb_decode_stage;
    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [2:0]  wb_addr, opcode, rs, rt, rd;
    logic [15:0] wb_data, read_data_1, read_data_2, sign_extended_immediate;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .read_data_1(read_data_1),
        .read_data_2(read_data_2), .sign_extended_immediate(sign_extended_immediate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] instr;
        logic        in_valid, out_ready, flush, wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        exp_valid;
        logic [2:0]  op, rs, rt, rd;
        logic [15:0] d1, d2, imm;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic o, input logic f,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd);
        instruction = i; in_valid = v; out_ready = o; flush = f;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_op, input logic [2:0] e_rs,
                             input logic [2:0] e_rt, input logic [2:0] e_rd,
                             input logic [15:0] e_d1, input logic [15:0] e_d2,
                             input logic [15:0] e_imm);
        check({tag, ".opcode"}, 32'(opcode), 32'(e_op));
        check({tag, ".rs"},     32'(rs),     32'(e_rs));
        check({tag, ".rt"},     32'(rt),     32'(e_rt));
        check({tag, ".rd"},     32'(rd),     32'(e_rd));
        check({tag, ".rd1"},    32'(read_data_1), 32'(e_d1));
        check({tag, ".rd2"},    32'(read_data_2), 32'(e_d2));
        check({tag, ".imm"},    32'(sign_extended_immediate), 32'(e_imm));
    endtask

    initial begin
        //             instr     v  ordy fl we  wa    wd        ev  op    rs    rt    rd    d1        d2        imm
        vecs[0] = '{16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000, 1, 3'd5, 3'd2, 3'd5, 3'd2, 16'h0000, 16'h0000, 16'h002A};
        vecs[1] = '{16'h0000, 0, 1, 0, 1, 3'd2, 16'h1234, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0000, 0, 1, 0, 1, 3'd5, 16'hBEEF, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000, 1, 3'd5, 3'd2, 3'd5, 3'd2, 16'h1234, 16'hBEEF, 16'h002A};
        vecs[4] = '{16'h807F, 1, 1, 0, 1, 3'd0, 16'h5555, 1, 3'd4, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[5] = '{16'h0000, 1, 1, 0, 0, 3'd0, 16'h0000, 1, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{16'hAAAA, 1, 1, 0, 1, 3'd2, 16'h00FF, 1, 3'd5, 3'd2, 3'd5, 3'd2, 16'h00FF, 16'hBEEF, 16'h002A};
        vecs[7] = '{16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000, 1, 3'd5, 3'd2, 3'd5, 3'd2, 16'h00FF, 16'hBEEF, 16'h002A};
        vecs[8] = '{16'h1500, 1, 1, 0, 1, 3'd5, 16'h0042, 1, 3'd0, 3'd5, 3'd2, 3'd0, 16'h0042, 16'h00FF, 16'h0000};

        rst = 1'b1;
        drive(16'h0000, 0, 0, 0, 0, 3'd0, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check_out("reset", 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].instr, vecs[i].in_valid, vecs[i].out_ready, vecs[i].flush,
                  vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
            @(negedge clk);
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                          vecs[i].d1, vecs[i].d2, vecs[i].imm);
        end

        // Stall: r2=00FF, r5=0042 held; write-backs refresh held operands.
        drive(16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("stall.load", 32'(out_valid), 32'd1);
        drive(16'h1500, 1, 0, 0, 0, 3'd0, 16'h0000);
        #1;
        check("stall.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("stall1.out_valid", 32'(out_valid), 32'd1);
        check_out("stall1", 3'd5, 3'd2, 3'd5, 3'd2, 16'h00FF, 16'h0042, 16'h002A);
        drive(16'h1500, 1, 0, 0, 1, 3'd5, 16'h0001);
        @(negedge clk);
        check_out("stall2", 3'd5, 3'd2, 3'd5, 3'd2, 16'h00FF, 16'h0001, 16'h002A);
        drive(16'h1500, 1, 0, 0, 1, 3'd2, 16'h0777);
        @(negedge clk);
        check("stall3.out_valid", 32'(out_valid), 32'd1);
        check_out("stall3", 3'd5, 3'd2, 3'd5, 3'd2, 16'h0777, 16'h0001, 16'h002A);
        drive(16'h0000, 0, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // Flush of a held instruction, then flush of a would-be load.
        drive(16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("flush.pre_valid", 32'(out_valid), 32'd1);
        drive(16'h1500, 1, 0, 1, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("flush.held", 32'(out_valid), 32'd0);
        drive(16'h1500, 1, 1, 1, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("flush.input_dropped", 32'(out_valid), 32'd0);
        drive(16'h0000, 0, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("flush.still_empty", 32'(out_valid), 32'd0);

        // Reset mid-stall overrides write-back and load, clears the register file.
        drive(16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check_out("prerst", 3'd5, 3'd2, 3'd5, 3'd2, 16'h0777, 16'h0001, 16'h002A);
        drive(16'h1500, 1, 0, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        drive(16'h1500, 1, 1, 0, 1, 3'd5, 16'h9999);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check_out("rst_mid", 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        drive(16'hAAAA, 1, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check("postrst.out_valid", 32'(out_valid), 32'd1);
        check_out("postrst", 3'd5, 3'd2, 3'd5, 3'd2, 16'h0000, 16'h0000, 16'h002A);
        drive(16'h1500, 1, 1, 0, 0, 3'd0, 16'h0000);
        @(negedge clk);
        check_out("postrst_r5", 3'd0, 3'd5, 3'd2, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
